mastermind_grader: RTL and testbench

- Grades a 4-position guess against a 4-position master pattern, Mastermind style. Each position holds a 3-bit shape code.
- Outputs:
  - Znarly: exact position-and-shape matches.
  - Zood: right shape in the wrong position.
- A small Moore control FSM (INIT/SAVE/HOLD), driven by the active-low Grade_it_L request, clears or loads a guess register.
- Grading is combinational from that register and masterPattern. Sits between the game's input/pattern logic and the score display.

---
 rtl/mastermind_pkg.sv | 34 +++
 rtl/mastermind_grader_if.sv | 28 ++
 rtl/mastermind_grader_fsm.sv | 47 ++++
 rtl/mastermind_grader.sv | 70 +++++++
 tb/tb_mastermind_grader.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mastermind_pkg.sv
// mastermind_pkg
// Shared types and constants for the Mastermind grader slice.
//   shape_t        : 3-bit shape codes. 000 and 111 are "no shape".
//   grader_state_t : states of the grade/clear control FSM.
//   shape_valid()  : true for the six real shape codes.
package mastermind_pkg;

  localparam int NUM_POS = 4;
  localparam int SHAPE_W = 3;
  localparam int PAT_W   = NUM_POS * SHAPE_W;
  localparam int CNT_W   = 4;

  typedef enum logic [SHAPE_W-1:0] {
    SH_NONE = 3'b000,
    SH_T    = 3'b001,
    SH_C    = 3'b010,
    SH_O    = 3'b011,
    SH_D    = 3'b100,
    SH_I    = 3'b101,
    SH_Z    = 3'b110,
    SH_BAD  = 3'b111
  } shape_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SAVE = 2'd1,
    ST_HOLD = 2'd2
  } grader_state_t;

  function automatic logic shape_valid(input logic [SHAPE_W-1:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

endpackage

// File: rtl/mastermind_grader_if.sv
// mastermind_grader_if
// Bundles the grader's request, pattern and score signals.
//   master : game side -- drives Grade_it_L, Guess, masterPattern; observes results.
//   slave  : grader side -- receives request/patterns; drives Guess_pos, Gload,
//            Gclr, Znarly, Zood.
interface mastermind_grader_if;
  import mastermind_pkg::*;

  logic             Grade_it_L;
  logic [PAT_W-1:0] Guess;
  logic [PAT_W-1:0] masterPattern;
  logic [PAT_W-1:0] Guess_pos;
  logic             Gload;
  logic             Gclr;
  logic [CNT_W-1:0] Znarly;
  logic [CNT_W-1:0] Zood;

  modport master (
    output Grade_it_L, Guess, masterPattern,
    input  Guess_pos, Gload, Gclr, Znarly, Zood
  );

  modport slave (
    input  Grade_it_L, Guess, masterPattern,
    output Guess_pos, Gload, Gclr, Znarly, Zood
  );

endinterface

// File: rtl/mastermind_grader_fsm.sv
// grader_fsm
// Moore control FSM for the grader. INIT and SAVE clear the guess register,
// HOLD loads it every cycle.
//   clk, rst    : rising-edge clock, async active-high reset
//   grade_it_l  : active-low grade/clear request
//   gclr, gload : registered controls, decoded purely from the state
module grader_fsm
  import mastermind_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic grade_it_l,
  output logic gclr,
  output logic gload
);

  grader_state_t state_q, state_d;
  logic          gclr_q, gload_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (!grade_it_l) state_d = ST_SAVE;
      ST_SAVE: if (grade_it_l)  state_d = ST_HOLD;
      ST_HOLD: if (!grade_it_l) state_d = ST_SAVE;
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs are registered alongside the state from the next-state value,
  // so they always equal the decode of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      gclr_q  <= 1'b1;
      gload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gclr_q  <= (state_d != ST_HOLD);
      gload_q <= (state_d == ST_HOLD);
    end
  end

  assign gclr  = gclr_q;
  assign gload = gload_q;

endmodule

// File: rtl/mastermind_grader.sv
// mastermind_grader
// Registers the guess under FSM control and grades it against masterPattern.
//   CLOCK_50 : rising-edge clock
//   reset    : async active-high reset
//   gif      : slave side of mastermind_grader_if (request, patterns, scores)
// Znarly counts exact matches; Zood counts right-shape/wrong-place matches.
module mastermind_grader
  import mastermind_pkg::*;
(
  input  logic                CLOCK_50,
  input  logic                reset,
  mastermind_grader_if.slave  gif
);

  logic             gclr, gload;
  logic [PAT_W-1:0] guess_pos_q, guess_pos_d;
  logic [CNT_W-1:0] znarly, matched;
  logic [2:0]       gc, mc;

  grader_fsm u_fsm (
    .clk        (CLOCK_50),
    .rst        (reset),
    .grade_it_l (gif.Grade_it_L),
    .gclr       (gclr),
    .gload      (gload)
  );

  // Clear wins over load.
  always_comb begin
    guess_pos_d = guess_pos_q;
    if (gclr)       guess_pos_d = '0;
    else if (gload) guess_pos_d = gif.Guess;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) guess_pos_q <= '0;
    else       guess_pos_q <= guess_pos_d;
  end

  // Total common shapes is the sum over shapes of min(guess count, master
  // count); removing the exact matches leaves the misplaced ones. Only codes
  // 1..6 are tallied, so the "no shape" codes never contribute.
  always_comb begin
    znarly  = '0;
    matched = '0;
    gc      = '0;
    mc      = '0;
    for (int p = 0; p < NUM_POS; p++) begin
      if (shape_valid(guess_pos_q[p*SHAPE_W +: SHAPE_W]) &&
          (guess_pos_q[p*SHAPE_W +: SHAPE_W] == gif.masterPattern[p*SHAPE_W +: SHAPE_W]))
        znarly = znarly + 4'd1;
    end
    for (int s = 1; s <= 6; s++) begin
      gc = '0;
      mc = '0;
      for (int p = 0; p < NUM_POS; p++) begin
        if (guess_pos_q[p*SHAPE_W +: SHAPE_W] == 3'(s))       gc = gc + 3'd1;
        if (gif.masterPattern[p*SHAPE_W +: SHAPE_W] == 3'(s)) mc = mc + 3'd1;
      end
      matched = matched + {1'b0, ((gc < mc) ? gc : mc)};
    end
  end

  assign gif.Guess_pos = guess_pos_q;
  assign gif.Gclr      = gclr;
  assign gif.Gload     = gload;
  assign gif.Znarly    = znarly;
  assign gif.Zood      = matched - znarly;

endmodule

// File: tb/tb_mastermind_grader.sv
// tb_mastermind_grader
// Directed bench for mastermind_grader. Each loaded guess pushes its expected
// register value and scores onto a queue; the entry is popped and compared
// one edge later when the DUT has registered the guess.
module tb_mastermind_grader;
  import mastermind_pkg::*;

  typedef struct {
    string       tag;
    logic [11:0] pos;
    logic [3:0]  zn;
    logic [3:0]  zo;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  mastermind_grader_if gif();

  mastermind_grader dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .gif      (gif)
  );

  function automatic logic [11:0] pat(input logic [2:0] p3, input logic [2:0] p2,
                                      input logic [2:0] p1, input logic [2:0] p0);
    return {p3, p2, p1, p0};
  endfunction

  task automatic checkVal(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s check did not hold", tag);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drive inputs and, when a load is expected on the next edge, queue the result.
  task automatic applyStimulus(input string tag, input logic grade_l, input logic [11:0] guess,
                               input logic [11:0] mp, input bit push,
                               input logic [11:0] epos, input logic [3:0] ezn, input logic [3:0] ezo);
    exp_t e;
    gif.Grade_it_L    = grade_l;
    gif.Guess         = guess;
    gif.masterPattern = mp;
    if (push) begin
      e.tag = tag; e.pos = epos; e.zn = ezn; e.zo = ezo;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
      return;
    end
    total--;
    e = sb.pop_front();
    checkVal({e.tag, "_pos"}, gif.Guess_pos, e.pos);
    checkVal({e.tag, "_zn"}, {8'h0, gif.Znarly}, {8'h0, e.zn});
    checkVal({e.tag, "_zo"}, {8'h0, gif.Zood}, {8'h0, e.zo});
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, "_gclr"}, {11'h0, gif.Gclr}, 12'h001);
    checkVal({tag, "_gload"}, {11'h0, gif.Gload}, 12'h000);
    checkVal({tag, "_pos"}, gif.Guess_pos, 12'h000);
    checkVal({tag, "_zn"}, {8'h0, gif.Znarly}, 12'h000);
    checkVal({tag, "_zo"}, {8'h0, gif.Zood}, 12'h000);
  endtask

  logic [11:0] m_izdt, m_oooo, m_junk;
  logic [11:0] g_ttcc, g_oodd, g_iicc, g_iotz, g_tizd, g_izdt, g_oooo;

  initial begin
    m_izdt = pat(SH_I, SH_Z, SH_D, SH_T);
    m_oooo = pat(SH_O, SH_O, SH_O, SH_O);
    m_junk = pat(SH_NONE, SH_BAD, SH_I, SH_T);
    g_ttcc = pat(SH_T, SH_T, SH_C, SH_C);
    g_oodd = pat(SH_O, SH_O, SH_D, SH_D);
    g_iicc = pat(SH_I, SH_I, SH_C, SH_C);
    g_iotz = pat(SH_I, SH_O, SH_T, SH_Z);
    g_tizd = pat(SH_T, SH_I, SH_Z, SH_D);
    g_izdt = m_izdt;
    g_oooo = m_oooo;

    // Reset and idle in INIT
    reset = 1'b1;
    applyStimulus("rst", 1'b1, g_ttcc, m_izdt, 1'b0, '0, '0, '0);
    #12;
    checkIdle("in_reset");
    reset = 1'b0;
    tick();
    checkIdle("init_idle");

    // INIT -> SAVE -> SAVE -> HOLD
    gif.Grade_it_L = 1'b0;
    tick();
    checkIdle("save1");
    tick();
    checkIdle("save2");
    gif.Grade_it_L = 1'b1;
    tick();
    checkVal("hold_gload", {11'h0, gif.Gload}, 12'h001);
    checkVal("hold_gclr", {11'h0, gif.Gclr}, 12'h000);
    checkVal("hold_pos", gif.Guess_pos, 12'h000);

    // Master IZDT, one guess per cycle
    applyStimulus("izdt_ttcc", 1'b1, g_ttcc, m_izdt, 1'b1, g_ttcc, 4'd0, 4'd1); tick(); checkOutput();
    applyStimulus("izdt_oodd", 1'b1, g_oodd, m_izdt, 1'b1, g_oodd, 4'd1, 4'd0); tick(); checkOutput();
    applyStimulus("izdt_iicc", 1'b1, g_iicc, m_izdt, 1'b1, g_iicc, 4'd1, 4'd0); tick(); checkOutput();
    applyStimulus("izdt_iotz", 1'b1, g_iotz, m_izdt, 1'b1, g_iotz, 4'd1, 4'd2); tick(); checkOutput();
    applyStimulus("izdt_tizd", 1'b1, g_tizd, m_izdt, 1'b1, g_tizd, 4'd0, 4'd4); tick(); checkOutput();
    applyStimulus("izdt_izdt", 1'b1, g_izdt, m_izdt, 1'b1, g_izdt, 4'd4, 4'd0); tick(); checkOutput();

    // Master change regrades the held guess without a clock edge
    gif.masterPattern = m_oooo;
    #1;
    checkVal("comb_master_zn", {8'h0, gif.Znarly}, 12'h000);
    checkVal("comb_master_zo", {8'h0, gif.Zood}, 12'h000);

    // Master OOOO
    applyStimulus("oooo_ttcc", 1'b1, g_ttcc, m_oooo, 1'b1, g_ttcc, 4'd0, 4'd0); tick(); checkOutput();
    applyStimulus("oooo_oodd", 1'b1, g_oodd, m_oooo, 1'b1, g_oodd, 4'd2, 4'd0); tick(); checkOutput();
    applyStimulus("oooo_iicc", 1'b1, g_iicc, m_oooo, 1'b1, g_iicc, 4'd0, 4'd0); tick(); checkOutput();
    applyStimulus("oooo_iotz", 1'b1, g_iotz, m_oooo, 1'b1, g_iotz, 4'd1, 4'd0); tick(); checkOutput();
    applyStimulus("oooo_tizd", 1'b1, g_tizd, m_oooo, 1'b1, g_tizd, 4'd0, 4'd0); tick(); checkOutput();
    applyStimulus("oooo_oooo", 1'b1, g_oooo, m_oooo, 1'b1, g_oooo, 4'd4, 4'd0); tick(); checkOutput();

    // No-shape codes never score, even when they line up
    applyStimulus("junk_swap", 1'b1, pat(SH_NONE, SH_BAD, SH_T, SH_I), m_junk, 1'b1,
                  pat(SH_NONE, SH_BAD, SH_T, SH_I), 4'd0, 4'd2); tick(); checkOutput();
    applyStimulus("junk_only", 1'b1, pat(SH_BAD, SH_BAD, SH_NONE, SH_NONE), m_junk, 1'b1,
                  pat(SH_BAD, SH_BAD, SH_NONE, SH_NONE), 4'd0, 4'd0); tick(); checkOutput();

    // Request from HOLD: one more load, then cleared on the following edge
    applyStimulus("leave_hold", 1'b0, g_iotz, m_izdt, 1'b1, g_iotz, 4'd1, 4'd2); tick(); checkOutput();
    checkVal("leave_gclr", {11'h0, gif.Gclr}, 12'h001);
    applyStimulus("cleared", 1'b0, g_izdt, m_izdt, 1'b1, 12'h000, 4'd0, 4'd0); tick(); checkOutput();
    applyStimulus("rehold", 1'b1, g_izdt, m_izdt, 1'b0, '0, '0, '0); tick();
    checkVal("rehold_gload", {11'h0, gif.Gload}, 12'h001);
    applyStimulus("rehold_tizd", 1'b1, g_tizd, m_izdt, 1'b1, g_tizd, 4'd0, 4'd4); tick(); checkOutput();

    // Asynchronous reset between edges while in HOLD
    #2;
    reset = 1'b1;
    #1;
    checkIdle("async_rst");
    #2;
    reset = 1'b0;
    tick();
    checkIdle("post_rst_init");
    gif.Grade_it_L = 1'b0;
    tick();
    gif.Grade_it_L = 1'b1;
    tick();
    checkVal("resume_gload", {11'h0, gif.Gload}, 12'h001);
    applyStimulus("resume_izdt", 1'b1, g_izdt, m_izdt, 1'b1, g_izdt, 4'd4, 4'd0); tick(); checkOutput();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
